// File: rtl/cache_burst_reader.sv
// cache_burst_reader
//   Read-side engine for the dual-port cache RAM. Accepts a (start_addr, burst_len)
//   command, drives the RAM read port (addrb, 1-cycle registered doutb) and returns
//   the words in address order on a valid/ready stream. A 4-entry FIFO absorbs the
//   RAM read latency and consumer backpressure.
//
//   Optional feature macro: CACHE_RD_STRIDE_EN
//     defined     : adds input 'stride', sampled with start; address step = stride
//     not defined : no stride port; address step = 1
//
// Ports
//   clk        in   1           clock, all registers on posedge
//   rst_n      in   1           synchronous active-low reset
//   start      in   1           command strobe, sampled only while idle
//   start_addr in   ADDR_WIDTH  first word address
//   burst_len  in   LEN_WIDTH   number of words (0 = empty burst, done only)
//   stride     in   ADDR_WIDTH  address step (only with CACHE_RD_STRIDE_EN)
//   busy       out  1           burst in progress
//   done       out  1           1-cycle completion pulse
//   ram_addrb  out  ADDR_WIDTH  RAM read address (registered)
//   ram_doutb  in   DATA_WIDTH  RAM read data, valid 1 cycle after addrb
//   m_data     out  DATA_WIDTH  stream data (FIFO head)
//   m_valid    out  1           stream valid
//   m_ready    in   1           stream ready
module cache_burst_reader #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 19,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  burst_len,
`ifdef CACHE_RD_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] stride,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_doutb,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ram_addrb_q, ram_addrb_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic                  v0_q, v0_d;
  logic                  v1_q, v1_d;
  logic                  done_q, done_d;
  logic [2:0]            count_q, count_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_mem [4];

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] start_step;
  logic                  push;
  logic                  pop;
  logic [2:0]            in_flight;

  // Address step: latched with the command when the stride feature is built in,
  // otherwise a constant increment of one word.
`ifdef CACHE_RD_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;

  assign step       = stride_q;
  assign start_step = stride;

  always_comb begin
    stride_d = stride_q;
    if (state_q == IDLE && start) begin
      stride_d = stride;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stride_q <= '0;
    end else begin
      stride_q <= stride_d;
    end
  end
`else
  assign step       = ADDR_WIDTH'(1);
  assign start_step = ADDR_WIDTH'(1);
`endif

  // v1 marks a word on ram_doutb this cycle; it lands in the FIFO at the coming edge.
  assign push      = v1_q;
  assign pop       = (count_q != 3'd0) && m_ready;
  // Words already owed to the FIFO: stored plus both read-pipe stages. Keeping this
  // at 3 or below before issuing means every issued read always has a FIFO slot.
  assign in_flight = count_q + {2'b00, v0_q} + {2'b00, v1_q};

  // Next-state logic for the FSM, read issue pipe and FIFO pointers.
  always_comb begin
    state_d     = state_q;
    ram_addrb_d = ram_addrb_q;
    next_addr_d = next_addr_q;
    len_d       = len_q;
    issued_d    = issued_q;
    v0_d        = 1'b0;
    v1_d        = v0_q;
    done_d      = 1'b0;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            // The accepting edge already issues the first read.
            state_d     = (burst_len == LEN_WIDTH'(1)) ? DRAIN : RUN;
            len_d       = burst_len;
            issued_d    = LEN_WIDTH'(1);
            ram_addrb_d = start_addr;
            next_addr_d = start_addr + start_step;
            v0_d        = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (issued_q != len_q && in_flight <= 3'd3) begin
          ram_addrb_d = next_addr_q;
          next_addr_d = next_addr_q + step;
          issued_d    = issued_q + LEN_WIDTH'(1);
          v0_d        = 1'b1;
          if (issued_q + LEN_WIDTH'(1) == len_q) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Everything is issued; the burst ends when the last stored word leaves
        // and nothing is left in the read pipe.
        if (pop && count_q == 3'd1 && !v0_q && !v1_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (push && !pop) begin
      count_d = count_q + 3'd1;
    end else if (!push && pop) begin
      count_d = count_q - 3'd1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 2'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ram_addrb_q <= '0;
      next_addr_q <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= 3'd0;
      rd_ptr_q    <= 2'd0;
      wr_ptr_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      ram_addrb_q <= ram_addrb_d;
      next_addr_q <= next_addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      done_q      <= done_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // FIFO storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= ram_doutb;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign ram_addrb = ram_addrb_q;
  assign m_valid   = (count_q != 3'd0);
  assign m_data    = m_valid ? fifo_mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_cache_burst_reader.sv
// tb_cache_burst_reader
//   Self-checking bench for cache_burst_reader. A behavioural RAM with a 1-cycle
//   registered read returns a fixed function of the address. Each command pushes
//   its expected words onto a scoreboard queue; beats are popped and compared as
//   the stream transfers them. Build with +define+CACHE_RD_STRIDE_EN to include
//   the stride scenario.
module tb_cache_burst_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [18:0] start_addr;
  logic [19:0] burst_len;
`ifdef CACHE_RD_STRIDE_EN
  logic [18:0] stride;
`endif
  logic        busy;
  logic        done;
  logic [18:0] ram_addrb;
  logic [11:0] ram_doutb;
  logic [11:0] m_data;
  logic        m_valid;
  logic        m_ready;

  int          checks;
  int          errors;
  logic [11:0] sbQ[$];

  cache_burst_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .burst_len  (burst_len),
`ifdef CACHE_RD_STRIDE_EN
    .stride     (stride),
`endif
    .busy       (busy),
    .done       (done),
    .ram_addrb  (ram_addrb),
    .ram_doutb  (ram_doutb),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents: ram[0x10+i] = 0x100+i, and distinct words across the wrap point.
  function automatic logic [11:0] ramWord(input logic [18:0] a);
    return a[11:0] + 12'h0F0 + {5'b0, a[18:12]};
  endfunction

  always @(posedge clk) ram_doutb <= ramWord(ram_addrb);

  // Drives a one-cycle start (idle-time command) and queues the expected words.
  // Returns at the falling edge right after the accepting edge.
  task automatic sendCmd(input logic [18:0] a, input logic [19:0] len, input logic [18:0] str);
    @(negedge clk);
    start      = 1'b1;
    start_addr = a;
    burst_len  = len;
`ifdef CACHE_RD_STRIDE_EN
    stride     = str;
`endif
    for (int i = 0; i < int'(len); i++) sbQ.push_back(ramWord(a + 19'(i) * str));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, m_valid, m_data, ram_addrb} !== 34'd0) begin
      errors++;
      $display("[TB] FAIL reset_values busy=%b done=%b m_valid=%b m_data=%h ram_addrb=%h expected all zero",
               busy, done, m_valid, m_data, ram_addrb);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [11:0] exp;
    m_ready = 1'b1;
    sendCmd(19'h00010, 20'd4, 19'd1);
    checks++;
    if (ram_addrb !== 19'h00010 || busy !== 1'b1 || m_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_first_issue ram_addrb=%h busy=%b m_valid=%b expected 00010 1 0",
               ram_addrb, busy, m_valid);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_latency m_valid=%b expected 0 one cycle after accept", m_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp = sbQ.pop_front();
      checks++;
      if (m_valid !== 1'b1 || m_data !== exp || exp !== 12'h100 + 12'(i)) begin
        errors++;
        $display("[TB] FAIL basic_beat%0d m_valid=%b m_data=%h expected 1 %h", i, m_valid, m_data,
                 12'h100 + 12'(i));
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_done done=%b busy=%b m_valid=%b expected 1 0 0", done, busy, m_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_done_pulse done=%b expected 0", done);
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] exp;
    logic [11:0] prevData;
    logic        prevStall;
    int          doneCount;
    prevStall = 1'b0;
    prevData  = '0;
    m_ready   = 1'b1;
    sendCmd(19'h00020, 20'd8, 19'd1);
    for (int cyc = 0; cyc < 200 && sbQ.size() != 0; cyc++) begin
      @(negedge clk);
      m_ready = (cyc % 2 == 0);
      if (prevStall) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== prevData) begin
          errors++;
          $display("[TB] FAIL bp_hold m_valid=%b m_data=%h expected 1 %h", m_valid, m_data, prevData);
        end
      end
      if (m_valid === 1'b1 && m_ready) begin
        exp = sbQ.pop_front();
        checks++;
        if (m_data !== exp) begin
          errors++;
          $display("[TB] FAIL bp_data m_data=%h expected %h", m_data, exp);
        end
      end
      prevStall = (m_valid === 1'b1) && !m_ready;
      prevData  = m_data;
    end
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL bp_timeout remaining=%0d expected 0", sbQ.size());
      sbQ.delete();
    end
    m_ready   = 1'b1;
    doneCount = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) doneCount++;
      if (cyc == 0) begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("[TB] FAIL bp_done done=%b busy=%b expected 1 0", done, busy);
        end
      end
    end
    checks++;
    if (doneCount != 1) begin
      errors++;
      $display("[TB] FAIL bp_done_count got=%0d expected 1", doneCount);
    end
  endtask

  task automatic test_wrap(input logic [18:0] a, input logic [18:0] str, input int len, input string tag);
    logic [11:0] exp;
    logic [18:0] expAddr;
    m_ready = 1'b1;
    sendCmd(a, 20'(len), str);
    for (int cyc = 0; cyc < 100 && sbQ.size() != 0; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc < len) begin
        expAddr = a + 19'(cyc) * str;
        checks++;
        if (ram_addrb !== expAddr) begin
          errors++;
          $display("[TB] FAIL %s_addr%0d ram_addrb=%h expected %h", tag, cyc, ram_addrb, expAddr);
        end
      end
      if (m_valid === 1'b1) begin
        exp = sbQ.pop_front();
        checks++;
        if (m_data !== exp) begin
          errors++;
          $display("[TB] FAIL %s_data m_data=%h expected %h", tag, m_data, exp);
        end
      end
    end
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout remaining=%0d expected 0", tag, sbQ.size());
      sbQ.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_len();
    int sawValid;
    int doneCount;
    m_ready = 1'b1;
    sendCmd(19'h00055, 20'd0, 19'd1);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_done done=%b busy=%b expected 1 0", done, busy);
    end
    sawValid  = 0;
    doneCount = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (m_valid === 1'b1 || busy === 1'b1) sawValid++;
      if (done === 1'b1) doneCount++;
    end
    checks++;
    if (sawValid != 0 || doneCount != 0) begin
      errors++;
      $display("[TB] FAIL zero_quiet valid_or_busy=%0d extra_done=%0d expected 0 0", sawValid, doneCount);
    end
  endtask

  task automatic test_mid_reset();
    logic [11:0] exp;
    int          beats;
    int          extra;
    m_ready = 1'b1;
    beats   = 0;
    sendCmd(19'h00030, 20'd8, 19'd1);
    for (int cyc = 0; cyc < 50 && beats < 3; cyc++) begin
      @(negedge clk);
      if (m_valid === 1'b1) begin
        exp = sbQ.pop_front();
        beats++;
        checks++;
        if (m_data !== exp) begin
          errors++;
          $display("[TB] FAIL rst_pre_data m_data=%h expected %h", m_data, exp);
        end
      end
    end
    rst_n = 1'b0;
    sbQ.delete();
    @(negedge clk);
    checks++;
    if ({busy, done, m_valid, m_data, ram_addrb} !== 34'd0) begin
      errors++;
      $display("[TB] FAIL rst_mid_values busy=%b done=%b m_valid=%b m_data=%h ram_addrb=%h expected all zero",
               busy, done, m_valid, m_data, ram_addrb);
    end
    rst_n = 1'b1;
    sendCmd(19'h00040, 20'd2, 19'd1);
    for (int cyc = 0; cyc < 50 && sbQ.size() != 0; cyc++) begin
      @(negedge clk);
      if (m_valid === 1'b1) begin
        exp = sbQ.pop_front();
        checks++;
        if (m_data !== exp) begin
          errors++;
          $display("[TB] FAIL rst_post_data m_data=%h expected %h", m_data, exp);
        end
      end
    end
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL rst_post_timeout remaining=%0d expected 0", sbQ.size());
      sbQ.delete();
    end
    extra = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (m_valid === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("[TB] FAIL rst_stale_words got=%0d expected 0", extra);
    end
  endtask

  task automatic test_busy_ignore();
    logic [11:0] exp;
    int          extra;
    m_ready = 1'b1;
    sendCmd(19'h00050, 20'd4, 19'd1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ignore_busy busy=%b expected 1", busy);
    end
    start      = 1'b1;
    start_addr = 19'h00060;
    burst_len  = 20'd4;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 50 && sbQ.size() != 0; cyc++) begin
      @(negedge clk);
      if (m_valid === 1'b1) begin
        exp = sbQ.pop_front();
        checks++;
        if (m_data !== exp) begin
          errors++;
          $display("[TB] FAIL ignore_data m_data=%h expected %h", m_data, exp);
        end
      end
    end
    if (sbQ.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL ignore_timeout remaining=%0d expected 0", sbQ.size());
      sbQ.delete();
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignore_done done=%b busy=%b expected 1 0", done, busy);
    end
    extra = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (m_valid === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("[TB] FAIL ignore_no_queue activity=%0d expected 0", extra);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    burst_len  = '0;
    m_ready    = 1'b0;
`ifdef CACHE_RD_STRIDE_EN
    stride     = 19'd1;
`endif
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap(19'h7FFFE, 19'd1, 4, "wrap");
    test_zero_len();
    test_mid_reset();
    test_busy_ignore();
`ifdef CACHE_RD_STRIDE_EN
    test_wrap(19'h00000, 19'd3, 3, "stride");
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
